uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from an upstream FIFO and shifts them out
// as 8N1-style frames (start, WIDTH data bits LSB first, optional parity, stop).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_n;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_n;
  logic             r_par;
  logic             w_par_n;
  logic             r_tx;
  logic             w_tx_n;
  logic             w_pop;
  logic             w_done;
  logic             w_last;

  // The baud counter only ever reaches CNT_MAX at the end of a bit, so a bit
  // boundary and a state change always coincide with the counter restarting.
  assign w_last = (r_cnt == CNT_MAX);

  // State register plus all datapath registers; tx is registered from the
  // value the next state will present so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
    end
  end

  // Next-state, counter, shift and line-level decode for the frame sequence.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_idx_n = '0;
        w_tx_n  = 1'b1;
        // The word and its parity are captured at the pop; FIFO activity
        // later in the frame cannot touch what is being sent.
        if (!fifo_empty) begin
          w_pop     = 1'b1;
          w_shift_n = fifo_data;
          w_par_n   = (^fifo_data) ^ (PARITY_ODD != 0);
          w_state_n = S_START;
          w_tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (w_last) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_n = '0;
          if (r_idx == IDX_MAX) begin
            if (PARITY_EN != 0) begin
              w_state_n = S_PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n = S_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_idx_n   = r_idx + 1'b1;
            w_shift_n = r_shift >> 1;
            w_tx_n    = w_shift_n[0];
          end
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_cnt_n   = '0;
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (w_last) begin
          w_cnt_n   = '0;
          w_done    = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  // Pop is masked by reset so nothing leaves the FIFO while the block is held.
  assign fifo_rd_en = w_pop & ~rst;
  assign busy       = (r_state != S_IDLE) | fifo_rd_en;
  assign tx_done    = w_done & ~rst;
  assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4, WIDTH=8.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Small FIFO model feeding the main (no-parity) instance.
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en, tx, busy, tx_done;
  int         n_pops = 0;
  int         n_rd_viol = 0;

  // Fixed single-word source for the two parity instances.
  logic [7:0] p_data = 8'h07;
  logic       p_empty = 1'b1;
  logic       pe_rd, pe_tx, pe_busy, pe_done;
  logic       po_rd, po_tx, po_busy, po_done;

  int n_checks = 0;
  int n_errors = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk(clk), .rst(rst), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_rd_en(pe_rd), .tx(pe_tx), .busy(pe_busy), .tx_done(pe_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk(clk), .rst(rst), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_rd_en(po_rd), .tx(po_tx), .busy(po_busy), .tx_done(po_done)
  );

  always #5 clk = ~clk;

  // FIFO read side: advance on pop, and flag any pop of an empty FIFO.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) n_rd_viol <= n_rd_viol + 1;
      else begin
        rd_ptr <= rd_ptr + 4'd1;
        n_pops <= n_pops + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  // Expected line level k cycles after the pop cycle (k=1 is first start-bit cycle).
  function automatic logic exp_tx(input logic [7:0] d, input int k, input logic pen, input logic pb);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else if (pen && b == 9) return pb;
    else return 1'b1;
  endfunction

  // Wait (bounded) for a pop, check the idle gap, then check a full 40-cycle frame.
  // Optionally pushes a new word into the FIFO at cycle push_k of the frame.
  task automatic check_frame(input string tag, input logic [7:0] d, input int exp_wait,
                             input int push_k, input logic [7:0] push_d);
    int w;
    w = 0;
    while (!fifo_rd_en && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    if (!fifo_rd_en) begin
      check_eq({tag, "_pop_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({tag, "_gap"}, w, exp_wait);
    check_eq({tag, "_busy_pop"}, busy, 1'b1);
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(negedge clk);
      if (k == push_k) push(push_d);
      #1;
      check_eq({tag, "_tx"}, tx, exp_tx(d, k, 1'b0, 1'b0));
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_done"}, tx_done, (k == 10 * CPB));
      check_eq({tag, "_rd"}, fifo_rd_en, 1'b0);
    end
  endtask

  initial begin
    int bad;
    // Reset behaviour (FIFO empty).
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rd", fifo_rd_en, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    rst = 1'b0;

    // Empty FIFO for 100 cycles: line stays quiet.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);
    check_eq("idle_pops", n_pops, 0);

    // Single word 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    @(negedge clk);
    push(8'hA5);
    #1;
    check_frame("a5", 8'hA5, 0, 0, 8'h00);
    @(negedge clk); #1;
    check_eq("a5_busy_after", busy, 1'b0);
    check_eq("a5_tx_after", tx, 1'b1);
    check_eq("a5_pops", n_pops, 1);

    // Three preloaded words, back-to-back; a write lands during the last frame.
    push(8'h00); push(8'hFF); push(8'h55);
    #1;
    check_frame("w00", 8'h00, 0, 0, 8'h00);
    check_frame("wff", 8'hFF, 1, 0, 8'h00);
    check_frame("w55", 8'h55, 1, 20, 8'h81);
    check_frame("w81", 8'h81, 1, 0, 8'h00);
    check_eq("burst_pops", n_pops, 5);

    // Reset during data bit 3 of 0x3C with another word waiting.
    @(negedge clk); #1;
    check_eq("pre3c_busy", busy, 1'b0);
    push(8'h3C);
    #1;
    check_eq("w3c_rd", fifo_rd_en, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
    end
    #1;
    check_eq("w3c_bit3", tx, 1'b1);
    push(8'h96);
    rst = 1'b1;
    #1;
    check_eq("midrst_rd", fifo_rd_en, 1'b0);
    @(negedge clk); #1;
    check_eq("midrst_tx", tx, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_rd2", fifo_rd_en, 1'b0);
    check_eq("midrst_pops", n_pops, 6);
    rst = 1'b0;
    #1;
    check_frame("w96", 8'h96, 0, 0, 8'h00);
    check_eq("total_pops", n_pops, 7);
    check_eq("rd_when_empty", n_rd_viol, 0);

    // Parity instances send 0x07: even parity bit 1, odd parity bit 0, 44 cycles.
    @(negedge clk);
    p_empty = 1'b0;
    #1;
    check_eq("par_even_rd", pe_rd, 1'b1);
    check_eq("par_odd_rd", po_rd, 1'b1);
    @(posedge clk);
    #1 p_empty = 1'b1;
    for (int k = 1; k <= 11 * CPB; k++) begin
      @(negedge clk); #1;
      check_eq("par_even_tx", pe_tx, exp_tx(8'h07, k, 1'b1, 1'b1));
      check_eq("par_odd_tx", po_tx, exp_tx(8'h07, k, 1'b1, 1'b0));
      check_eq("par_even_done", pe_done, (k == 11 * CPB));
      check_eq("par_odd_done", po_done, (k == 11 * CPB));
    end
    @(negedge clk); #1;
    check_eq("par_even_busy_after", pe_busy, 1'b0);
    check_eq("par_odd_busy_after", po_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
